// File: rtl/uart_pkg.sv
// Shared definitions for the serial transmit path: frame FSM states,
// the idle line level and a constant-width helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START_BIT,
      DATA_BITS,
      PARITY_BIT,
      STOP_BIT
   } tx_state_e;

   localparam logic UART_IDLE_LEVEL = 1'b1;

   // Smallest n with 2**n >= value; 0 for value <= 1.
   function automatic int CeilLog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/uart_frame_tx_timer.sv
// Bit-period timer: counts enabled cycles and raises flag on the last
// count of each period, then wraps to zero.
module bit_period_timer
   import uart_pkg::*;
#(
   parameter int MAXIMUM_VALUE = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic sync_clear,
   output logic flag
);

   localparam int CW = (CeilLog2(MAXIMUM_VALUE) < 1) ? 1 : CeilLog2(MAXIMUM_VALUE);
   localparam logic [CW-1:0] LAST_COUNT = CW'(MAXIMUM_VALUE - 1);

   logic [CW-1:0] count_q, count_d;

   assign flag = (count_q == LAST_COUNT);

   always_comb begin
      count_d = count_q;
      if (sync_clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = flag ? '0 : count_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/uart_frame_tx.sv
// Asynchronous serial frame transmitter: start bit, LSB-first payload,
// optional parity bit and one or two stop bits, with a ready/start handshake.
module uart_frame_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  ready,
   output logic                  tx,
   output logic                  done
);

   localparam int IW = (CeilLog2(DATA_WIDTH) < 1) ? 1 : CeilLog2(DATA_WIDTH);
   localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_WIDTH - 1);
   localparam logic          LAST_STOP = (STOP_BITS > 1);
   localparam logic          ODD_BIT   = (PARITY_ODD != 0);

   tx_state_e             state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [IW-1:0]         bit_idx_q, bit_idx_d;
   logic                  stop_q, stop_d;
   logic                  parity_q, parity_d;
   logic                  tx_q, tx_d;
   logic                  done_q, done_d;
   logic                  accept;
   logic                  bit_end;
   logic                  timer_clear;
   logic                  timer_enable;

   bit_period_timer #(
      .MAXIMUM_VALUE (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk        (clk),
      .rst        (rst),
      .enable     (timer_enable),
      .sync_clear (timer_clear),
      .flag       (bit_end)
   );

   assign timer_enable = (state_q != IDLE);
   assign ready        = (state_q == IDLE);
   assign tx           = tx_q;
   assign done         = done_q;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      stop_d    = stop_q;
      parity_d  = parity_q;
      done_d    = 1'b0;
      accept    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               shift_d   = data_in;
               // Parity of the word as latched; later data_in changes cannot reach it.
               parity_d  = (^data_in) ^ ODD_BIT;
               bit_idx_d = '0;
               stop_d    = 1'b0;
               state_d   = START_BIT;
            end
         end
         START_BIT: begin
            if (bit_end) state_d = DATA_BITS;
         end
         DATA_BITS: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_idx_q == LAST_IDX) begin
                  bit_idx_d = '0;
                  state_d   = (PARITY_EN != 0) ? PARITY_BIT : STOP_BIT;
               end else begin
                  bit_idx_d = bit_idx_q + IW'(1);
               end
            end
         end
         PARITY_BIT: begin
            if (bit_end) state_d = STOP_BIT;
         end
         STOP_BIT: begin
            if (bit_end) begin
               if (stop_q == LAST_STOP) begin
                  stop_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  stop_d = stop_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      timer_clear = accept || (state_d != state_q);

      // tx is registered, so it is derived from the upcoming state/shift value.
      case (state_d)
         START_BIT:  tx_d = 1'b0;
         DATA_BITS:  tx_d = shift_d[0];
         PARITY_BIT: tx_d = parity_d;
         default:    tx_d = UART_IDLE_LEVEL;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
         stop_q    <= 1'b0;
         parity_q  <= 1'b0;
         tx_q      <= UART_IDLE_LEVEL;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         stop_q    <= stop_d;
         parity_q  <= parity_d;
         tx_q      <= tx_d;
         done_q    <= done_d;
      end
   end

endmodule
